carry_look_ahead_adder: RTL and testbench

CARRY_LOOK_AHEAD_ADDER -- requirements
Module: carry_look_ahead_adder

---
 rtl/adder_pkg.sv | 9 +
 rtl/cla_group.sv | 50 +++++
 rtl/carry_look_ahead_adder.sv | 79 +++++++
 tb/tb_carry_look_ahead_adder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared sizing for the carry-lookahead adder: default operand width, lookahead group
// size and the resulting number of groups.
package adder_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_BLOCK = 4;
   localparam int NUM_GROUPS    = DEFAULT_WIDTH / DEFAULT_BLOCK;

endpackage

// File: rtl/cla_group.sv
// One lookahead group: flattened sum-of-products carries from local generate/propagate,
// plus the group G/P terms that feed the second-level lookahead unit.
module cla_group #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] s,
   output logic             g_grp,
   output logic             p_grp,
   output logic             msb_cin
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is an OR of product terms: a generate (or cin) ANDed with every
   // propagate above it, so no carry depends on a neighbouring carry.
   always_comb begin
      logic term;
      c     = '0;
      g_grp = 1'b0;
      term  = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
         term = cin;
         for (int k = 0; k < i; k++) term = term & p[k];
         c[i] = c[i] | term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j; k < i; k++) if (k != j) term = term & p[k];
            c[i] = c[i] | term;
         end
      end
      for (int j = 0; j < BLOCK; j++) begin
         term = g[j];
         for (int k = j; k < BLOCK; k++) if (k != j) term = term & p[k];
         g_grp = g_grp | term;
      end
   end

   assign p_grp   = &p;
   assign s       = p ^ c;
   assign msb_cin = c[BLOCK-1];

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry-lookahead adder with registered sum, signed-overflow flag and valid.
// Carry-in is fixed at zero; the final carry-out only feeds the overflow term.
module carry_look_ahead_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int BLOCK = DEFAULT_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             valid_in,
   output logic [WIDTH-1:0] sum,
   output logic             overflow,
   output logic             valid_out
);

   localparam int GROUPS = WIDTH / BLOCK;

   logic [GROUPS-1:0][BLOCK-1:0] a_grp;
   logic [GROUPS-1:0][BLOCK-1:0] b_grp;
   logic [GROUPS-1:0][BLOCK-1:0] s_grp;
   logic [GROUPS-1:0]            grp_g;
   logic [GROUPS-1:0]            grp_p;
   logic [GROUPS-1:0]            grp_cin;
   logic [GROUPS-1:0]            msb_carry;
   logic                         carry_out;
   logic                         ovf_next;

   assign a_grp = a;
   assign b_grp = b;

   for (genvar k = 0; k < GROUPS; k++) begin : g_group
      cla_group #(.BLOCK(BLOCK)) u_group (
         .a       (a_grp[k]),
         .b       (b_grp[k]),
         .cin     (grp_cin[k]),
         .s       (s_grp[k]),
         .g_grp   (grp_g[k]),
         .p_grp   (grp_p[k]),
         .msb_cin (msb_carry[k])
      );
   end

   // Second-level lookahead: every group carry-in is its own flattened equation over
   // the group G/P terms, with the adder carry-in tied to zero.
   always_comb begin
      logic term;
      grp_cin = '0;
      term    = 1'b0;
      for (int i = 1; i < GROUPS; i++) begin
         for (int j = 0; j < i; j++) begin
            term = grp_g[j];
            for (int k = j; k < i; k++) if (k != j) term = term & grp_p[k];
            grp_cin[i] = grp_cin[i] | term;
         end
      end
   end

   assign carry_out = grp_g[GROUPS-1] | (grp_p[GROUPS-1] & grp_cin[GROUPS-1]);
   assign ovf_next  = msb_carry[GROUPS-1] ^ carry_out;

   // Results load only on accepted operands; valid_out tracks valid_in each edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum       <= '0;
         overflow  <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            sum      <= s_grp;
            overflow <= ovf_next;
         end
      end
   end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Directed vector table, reset/hold sequences and a random run against a ripple-carry
// reference model for the carry-lookahead adder.
module tb_carry_look_ahead_adder;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_sum;
      logic         exp_ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         valid_in;
   logic [W-1:0] sum;
   logic         overflow;
   logic         valid_out;

   int total = 0;
   int bad   = 0;

   carry_look_ahead_adder #(.WIDTH(W), .BLOCK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .valid_in  (valid_in),
      .sum       (sum),
      .overflow  (overflow),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] ripple(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] s;
      logic         c;
      logic         c_msb;
      c     = 1'b0;
      c_msb = 1'b0;
      for (int i = 0; i < W; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         if (i == W - 1) c_msb = c;
         c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c_msb ^ c, s};
   endfunction

   task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [W-1:0] es, input logic eo, input logic ev);
      check_val({name, " sum"}, sum, es);
      check_val({name, " overflow"}, {31'd0, overflow}, {31'd0, eo});
      check_val({name, " valid_out"}, {31'd0, valid_out}, {31'd0, ev});
   endtask

   task automatic drive(input logic rn, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      rst_n    = rn;
      valid_in = v;
      a        = x;
      b        = y;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      logic [W:0]   m;
      logic [W-1:0] model_sum;
      logic         model_ovf;
      logic         v;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1});
      vecs.push_back('{32'h80000000, 32'h80000000, 32'h00000000, 1'b1});
      vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
      vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1});
      vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{32'h1A2B3C4D, 32'h5F6E7D8C, 32'h7999B9D9, 1'b0});
      vecs.push_back('{32'h12345678, 32'h87654321, 32'h99999999, 1'b0});
      vecs.push_back('{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{32'h00000000, 32'h00000000, 32'h00000000, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
      vecs.push_back('{32'h40000000, 32'h40000000, 32'h80000000, 1'b1});
      vecs.push_back('{32'h0000000F, 32'h00000001, 32'h00000010, 1'b0});
      vecs.push_back('{32'h0FFFFFFF, 32'h00000001, 32'h10000000, 1'b0});
      vecs.push_back('{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{32'hC0000000, 32'hBFFFFFFF, 32'h7FFFFFFF, 1'b1});

      rst_n    = 1'b0;
      valid_in = 1'b1;
      a        = 32'h12345678;
      b        = 32'h11111111;
      @(posedge clk);
      #1;
      check_out("reset with valid_in high", 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      check_out("reset idle", 32'h0, 1'b0, 1'b0);

      // Back-to-back accepted operands, one result per cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(1'b1, 1'b1, vecs[i].a, vecs[i].b);
         check_out($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_ovf, 1'b1);
      end

      drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h01010101);
      check_out("hold after idle", 32'h7FFFFFFF, 1'b1, 1'b0);

      drive(1'b1, 1'b1, 32'h11111111, 32'h22222222);
      check_out("load before reset", 32'h33333333, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001);
      check_out("mid-stream reset", 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001);
      check_out("release idle holds zero", 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h7FFFFFFF, 32'h00000001);
      check_out("first after reset", 32'h80000000, 1'b1, 1'b1);

      model_sum = 32'h80000000;
      model_ovf = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         v  = ($urandom_range(0, 7) != 0);
         ra = $urandom;
         rb = $urandom;
         if (n % 16 == 0) ra = 32'h80000000;
         if (n % 16 == 1) rb = 32'hFFFFFFFF;
         if (n % 16 == 2) ra = 32'h7FFFFFFF;
         drive(1'b1, v, ra, rb);
         if (v) begin
            m         = ripple(ra, rb);
            model_sum = m[W-1:0];
            model_ovf = m[W];
         end
         total++;
         if (sum !== model_sum || overflow !== model_ovf || valid_out !== v) begin
            bad++;
            $display("[TB] FAIL random%0d: got sum=0x%08h ovf=%b vo=%b expected sum=0x%08h ovf=%b vo=%b",
                     n, sum, overflow, valid_out, model_sum, model_ovf, v);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
